fp_align_unpack: RTL and testbench
==================================

Name: fp_align_unpack

Overview:
- Front-end operand stage of the FP add/sub pipeline; the inverse counterpart of the post-add/post-multiply normalize-and-round stage.
- Accepts two IEEE-754 single-precision words and unpacks sign, exponent and mantissa with the hidden bit.
- Classifies exceptions, orders the operands by magnitude, and right-aligns the smaller mantissa to the larger exponent with guard/round/sticky bits.
- The alignment shifter is iterative: SHIFT_STEP bits per cycle, with valid/ready handshakes on both sides.

Parameters:
SHIFT_STEP, 4, bits shifted per ALIGN cycle (legal 1..8)
MAX_SHIFT, 27, clamp on the exponent difference (24 mantissa bits + 3 GRS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept; high only in IDLE
a  in  32  operand A (IEEE-754 single)
b  in  32  operand B (IEEE-754 single)
sub  in  1  1 = A-B; inverts B's sign at capture
out_valid  out  1  aligned result valid
out_ready  in  1  downstream accepts
sign_big  out  1  sign of larger-magnitude operand
sign_small  out  1  sign of smaller operand
eff_sub  out  1  sign_big ^ sign_small
exp_common  out  8  larger exponent
mant_big  out  24  larger mantissa {hidden,frac}
mant_small  out  27  aligned smaller mantissa {24 bits, G, R, S}
swap  out  1  1 = B was larger
exception  out  1  either operand exponent==255, or exponent==0 with frac!=0

Behaviour:
- Reset: state IDLE; all outputs and internal registers 0; in_ready=1 (combinational, state==IDLE); out_valid=0.
- Reset mid-transaction: the transaction is discarded and the block returns to IDLE. No partial output.
- IDLE: on in_valid&&in_ready, capture a, and b with sign b[31]^sub.
  - Hidden bit = (exp!=0); zero operand gives mantissa 0.
  - swap = (expB>expA) || (expB==expA && fracB>fracA).
  - Big operand goes to exp_common/mant_big/sign_big.
  - mant_small = {small_mant,3'b0}.
  - cnt = min(exp_big-exp_small, MAX_SHIFT).
- Next state after capture:
  - exception: DONE, with mant_big=0, mant_small=0, exp_common=0, exception=1.
  - cnt==0: DONE.
  - otherwise: ALIGN.
- ALIGN, each cycle:
  - sh = min(cnt, SHIFT_STEP).
  - mant_small = (mant_small>>sh) with bit0 |= OR of all bits shifted out (sticky accumulates).
  - cnt -= sh; when the new cnt==0, go to DONE.
- DONE: out_valid=1; all outputs held stable while out_ready=0. On out_ready, go to IDLE and deassert out_valid the next cycle.
- Latency (accept edge to out_valid) = 1 + ceil(cnt/SHIFT_STEP) cycles. Throughput: one transaction per latency+1 cycles minimum, since there is no accept in DONE.
- Widths:
  - cnt is 5 bits.
  - The exponent difference is computed at 9 bits before clamping; there is no wrap-around.
  - A shift of 27 leaves only sticky, so mant_small = 27'h1 if the mantissa was nonzero, else 0.
- in_valid while not IDLE is ignored; the upstream must hold it.

Decomposition:
- fp_pkg:
  - EXP_W=8, FRAC_W=23, MANT_W=24, GRS_W=3, EXP_MAX=8'hFF.
  - State enum {IDLE, ALIGN, DONE}.
- Sub-module fp_classify (combinational, one instance per operand): word in → sign, exp, mant24, is_zero, is_exc.
- FSM, counter and shifter live in fp_align_unpack.

Test Plan:
1. a=3F800000, b=3F800000, sub=0 → out_valid 1 cycle after accept: exp_common=7F, mant_big=800000, mant_small=27'h4000000, swap=0, eff_sub=0.
2. a=3F800000, b=41000000, sub=1 → latency 2: swap=1, exp_common=82, mant_small=27'h0800000, sign_big=1, eff_sub=1.
3. a=4B800000, b=3F800001 (diff 24) → latency 7: mant_small=27'h5 (sticky set), exception=0.
4. a=7F000000, b=3F800000 (diff 127, clamped to 27) → latency 8: mant_small=27'h1; a=7F800000 → exception=1, mantissas 0, latency 1.
5. Backpressure: out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, new in_valid ignored; out_ready=1 → IDLE, in_ready=1 the next cycle.
6. Reset pulse during ALIGN (case 3, cycle 3) → out_valid=0 and all outputs 0 immediately; in_ready=1 after release; the following transaction produces correct results.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision field widths, constants and the align-stage state encoding.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int GRS_W  = 3;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    DONE
  } state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack of one IEEE-754 single: sign, exponent, mantissa with hidden bit, class flags.
// Zero latency, no flow control.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0]       i_word,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MANT_W-1:0] o_mant,
  output logic              o_is_zero,
  output logic              o_is_exc
);

  logic [FRAC_W-1:0] w_frac;

  assign o_sign    = i_word[31];
  assign o_exp     = i_word[30:FRAC_W];
  assign w_frac    = i_word[FRAC_W-1:0];
  assign o_mant    = {(o_exp != '0), w_frac};
  assign o_is_zero = (o_exp == '0) && (w_frac == '0);
  // Denormals are routed to the exception path along with Inf/NaN.
  assign o_is_exc  = (o_exp == EXP_MAX) || ((o_exp == '0) && (w_frac != '0));

endmodule

// File: rtl/fp_align_unpack.sv
// FP add/sub operand stage: unpack, order by magnitude, iteratively align smaller mantissa with GRS.
// Latency 1 + ceil(shift/SHIFT_STEP); in_ready only in IDLE, outputs held in DONE until out_ready.
module fp_align_unpack
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 4,
  parameter int MAX_SHIFT  = 27
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             a,
  input  logic [31:0]             b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sign_big,
  output logic                    sign_small,
  output logic                    eff_sub,
  output logic [EXP_W-1:0]        exp_common,
  output logic [MANT_W-1:0]       mant_big,
  output logic [MANT_W+GRS_W-1:0] mant_small,
  output logic                    swap,
  output logic                    exception
);

  localparam int ALN_W = MANT_W + GRS_W;
  localparam logic [4:0]       STEP_C  = 5'(SHIFT_STEP);
  localparam logic [4:0]       CNT_MAX = 5'(MAX_SHIFT);
  localparam logic [8:0]       DIFF_MX = 9'(MAX_SHIFT);
  localparam logic [ALN_W-1:0] ONE_C   = ALN_W'(1);

  state_t r_state;
  state_t w_next_state;

  logic [4:0]        r_cnt;
  logic              r_sign_big;
  logic              r_sign_small;
  logic [EXP_W-1:0]  r_exp;
  logic [MANT_W-1:0] r_mant_big;
  logic [ALN_W-1:0]  r_mant_small;
  logic              r_swap;
  logic              r_exc;

  logic              w_sign_a, w_sign_b_raw, w_sign_b;
  logic [EXP_W-1:0]  w_exp_a, w_exp_b;
  logic [MANT_W-1:0] w_mant_a, w_mant_b;
  logic              w_zero_a, w_zero_b;
  logic              w_exc_a, w_exc_b;

  fp_classify u_cls_a (
    .i_word    (a),
    .o_sign    (w_sign_a),
    .o_exp     (w_exp_a),
    .o_mant    (w_mant_a),
    .o_is_zero (w_zero_a),
    .o_is_exc  (w_exc_a)
  );

  fp_classify u_cls_b (
    .i_word    (b),
    .o_sign    (w_sign_b_raw),
    .o_exp     (w_exp_b),
    .o_mant    (w_mant_b),
    .o_is_zero (w_zero_b),
    .o_is_exc  (w_exc_b)
  );

  // Capture-side operand ordering and initial shift count.
  logic              w_swap;
  logic              w_exc;
  logic [EXP_W-1:0]  w_exp_big, w_exp_small;
  logic [MANT_W-1:0] w_mant_big, w_mant_small_raw, w_mant_small;
  logic              w_small_zero;
  logic [8:0]        w_diff;
  logic [4:0]        w_cnt_init;
  logic              w_accept;

  assign w_sign_b = w_sign_b_raw ^ sub;
  assign w_swap   = (w_exp_b > w_exp_a) ||
                    ((w_exp_b == w_exp_a) && (w_mant_b[FRAC_W-1:0] > w_mant_a[FRAC_W-1:0]));
  assign w_exc    = w_exc_a | w_exc_b;

  assign w_exp_big        = w_swap ? w_exp_b  : w_exp_a;
  assign w_exp_small      = w_swap ? w_exp_a  : w_exp_b;
  assign w_mant_big       = w_swap ? w_mant_b : w_mant_a;
  assign w_mant_small_raw = w_swap ? w_mant_a : w_mant_b;
  assign w_small_zero     = w_swap ? w_zero_a : w_zero_b;
  assign w_mant_small     = w_small_zero ? '0 : w_mant_small_raw;

  assign w_diff     = {1'b0, w_exp_big} - {1'b0, w_exp_small};
  assign w_cnt_init = (w_diff > DIFF_MX) ? CNT_MAX : w_diff[4:0];
  assign w_accept   = in_valid && (r_state == IDLE);

  // One alignment step; bits falling off the bottom fold into the sticky bit.
  logic [4:0]       w_sh;
  logic [4:0]       w_cnt_next;
  logic [ALN_W-1:0] w_mask;
  logic             w_lost;
  logic [ALN_W-1:0] w_shifted;

  assign w_sh       = (r_cnt < STEP_C) ? r_cnt : STEP_C;
  assign w_cnt_next = r_cnt - w_sh;
  assign w_mask     = (ONE_C << w_sh) - ONE_C;
  assign w_lost     = |(r_mant_small & w_mask);
  assign w_shifted  = (r_mant_small >> w_sh) | {{(ALN_W-1){1'b0}}, w_lost};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_exc || (w_cnt_init == '0)) begin
            w_next_state = DONE;
          end else begin
            w_next_state = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (w_cnt_next == '0) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_sign_big   <= 1'b0;
      r_sign_small <= 1'b0;
      r_exp        <= '0;
      r_mant_big   <= '0;
      r_mant_small <= '0;
      r_swap       <= 1'b0;
      r_exc        <= 1'b0;
    end else if (w_accept) begin
      r_sign_big   <= w_swap ? w_sign_b : w_sign_a;
      r_sign_small <= w_swap ? w_sign_a : w_sign_b;
      r_swap       <= w_swap;
      r_exc        <= w_exc;
      if (w_exc) begin
        r_exp        <= '0;
        r_mant_big   <= '0;
        r_mant_small <= '0;
        r_cnt        <= '0;
      end else begin
        r_exp        <= w_exp_big;
        r_mant_big   <= w_mant_big;
        r_mant_small <= {w_mant_small, {GRS_W{1'b0}}};
        r_cnt        <= w_cnt_init;
      end
    end else if (r_state == ALIGN) begin
      r_mant_small <= w_shifted;
      r_cnt        <= w_cnt_next;
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign sign_big   = r_sign_big;
  assign sign_small = r_sign_small;
  assign eff_sub    = r_sign_big ^ r_sign_small;
  assign exp_common = r_exp;
  assign mant_big   = r_mant_big;
  assign mant_small = r_mant_small;
  assign swap       = r_swap;
  assign exception  = r_exc;

endmodule

// File: tb/tb_fp_align_unpack.sv
// Scoreboarded bench for fp_align_unpack: directed corner cases plus randomized operand pairs.
module tb_fp_align_unpack;

  localparam int STEP = 4;
  localparam int MAXS = 27;

  typedef struct {
    logic        sb;
    logic        ss;
    logic        es;
    logic        sw;
    logic        exc;
    logic [7:0]  ex;
    logic [23:0] mb;
    logic [26:0] ms;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign_big, sign_small, eff_sub, swap, exception;
  logic [7:0]  exp_common;
  logic [23:0] mant_big;
  logic [26:0] mant_small;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  exp_t sbq[$];

  fp_align_unpack #(.SHIFT_STEP(STEP), .MAX_SHIFT(MAXS)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign_big   (sign_big),
    .sign_small (sign_small),
    .eff_sub    (eff_sub),
    .exp_common (exp_common),
    .mant_big   (mant_big),
    .mant_small (mant_small),
    .swap       (swap),
    .exception  (exception)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       out_ready = 1'b0;
      2:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: order by |value| (bit pattern without sign), shift by clamped exponent gap, OR lost bits into LSB.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t   r;
    logic   sa, sb;
    bit     sw, exa, exb;
    int     ea, eb, d, cnt;
    longint mx, my, mbig, msml, m, lost;
    sa  = x[31];
    sb  = y[31] ^ s;
    ea  = int'(x[30:23]);
    eb  = int'(y[30:23]);
    exa = (ea == 255) || (ea == 0 && x[22:0] != 23'd0);
    exb = (eb == 255) || (eb == 0 && y[22:0] != 23'd0);
    mx  = (ea != 0) ? (longint'(x[22:0]) + (longint'(1) << 23)) : longint'(0);
    my  = (eb != 0) ? (longint'(y[22:0]) + (longint'(1) << 23)) : longint'(0);
    sw  = (y[30:0] > x[30:0]);
    r.sb  = sw ? sb : sa;
    r.ss  = sw ? sa : sb;
    r.es  = sa ^ sb;
    r.sw  = sw;
    r.exc = exa | exb;
    r.acc = 0;
    if (r.exc) begin
      r.ex  = 8'd0;
      r.mb  = 24'd0;
      r.ms  = 27'd0;
      r.lat = 1;
    end else begin
      d    = sw ? (eb - ea) : (ea - eb);
      cnt  = (d > MAXS) ? MAXS : d;
      mbig = sw ? my : mx;
      msml = sw ? mx : my;
      m    = msml * 8;
      lost = m & ((longint'(1) << cnt) - 1);
      r.ex  = 8'(sw ? eb : ea);
      r.mb  = 24'(mbig);
      r.ms  = 27'((m >> cnt) | ((lost != 0) ? longint'(1) : longint'(0)));
      r.lat = 1 + (cnt + STEP - 1) / STEP;
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_op(input int base);
    int          e;
    logic [22:0] f;
    case ($urandom_range(0, 9))
      0:       e = 0;
      1:       e = 255;
      2, 3:    e = int'($urandom_range(0, 255));
      default: begin
        e = base + int'($urandom_range(0, 40)) - 20;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
      end
    endcase
    f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom_range(0, 1)), 8'(e), f};
  endfunction

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_op, input logic ts, input bit expect_it);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = ta;
    b        = tb_op;
    sub      = ts;
    n        = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        in_valid = 1'b0;
        return;
      end
    end
    if (expect_it) begin
      e     = model(ta, tb_op, ts);
      e.acc = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    rdy_mode = 2;
    while ((sbq.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", sbq.size());
    end
  endtask

  // Monitor: first out_valid cycle of each result is scored, later DONE cycles must hold steady.
  bit          active = 0;
  logic [63:0] held, cur;
  exp_t        em;

  always @(negedge clk) begin
    if (!reset) begin
      active = 0;
    end else if (out_valid) begin
      cur = {sign_big, sign_small, eff_sub, exp_common, mant_big, mant_small, swap, exception};
      if (!active) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result %0h with nothing outstanding", cur);
        end else begin
          em = sbq.pop_front();
          chk("sign_big",   64'(sign_big),   64'(em.sb));
          chk("sign_small", 64'(sign_small), 64'(em.ss));
          chk("eff_sub",    64'(eff_sub),    64'(em.es));
          chk("swap",       64'(swap),       64'(em.sw));
          chk("exception",  64'(exception),  64'(em.exc));
          chk("exp_common", 64'(exp_common), 64'(em.ex));
          chk("mant_big",   64'(mant_big),   64'(em.mb));
          chk("mant_small", 64'(mant_small), 64'(em.ms));
          chk("latency",    64'(cyc - em.acc + 1), 64'(em.lat));
        end
        held   = cur;
        active = 1;
      end else begin
        chk("hold_stable", cur, held);
      end
      if (out_ready) active = 0;
    end
  end

  initial begin
    int base;
    int n;
    logic [31:0] x, y;

    #2;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", {sign_big, sign_small, eff_sub, exp_common, mant_big, mant_small, swap, exception}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    send(32'h3F800000, 32'h3F800000, 1'b0, 1);
    send(32'h3F800000, 32'h41000000, 1'b1, 1);
    send(32'h4B800000, 32'h3F800001, 1'b0, 1);
    send(32'h7F000000, 32'h3F800000, 1'b0, 1);
    send(32'h7F800000, 32'h3F800000, 1'b0, 1);
    send(32'h00000000, 32'h3F800000, 1'b1, 1);
    send(32'h00000001, 32'h3F800000, 1'b0, 1);
    drain();

    // Backpressure in DONE with a competing request on in_valid.
    rdy_mode = 1;
    send(32'h40400000, 32'h3F000000, 1'b0, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_valid_held",   64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("bp_release_in_ready",  64'(in_ready),  64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    drain();

    // Reset in the middle of alignment discards the transaction.
    send(32'h4B800000, 32'h3F800001, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_align_busy", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_outputs", {sign_big, sign_small, eff_sub, exp_common, mant_big, mant_small, swap, exception}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    send(32'h4B800000, 32'h3F800001, 1'b0, 1);
    drain();

    @(negedge clk);
    rdy_mode = 0;
    for (int i = 0; i < 200; i++) begin
      base = int'($urandom_range(1, 254));
      x = rnd_op(base);
      y = ($urandom_range(0, 15) == 0) ? (x ^ 32'h80000000) : rnd_op(base);
      send(x, y, 1'($urandom_range(0, 1)), 1);
    end
    drain();
    repeat (40) @(posedge clk);
    chk("queue_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
